// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div and
// handles mthi/mtlo writes plus the combinational mfhi/mflo read path.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  hilo_op,
  input  logic [1:0]  whilo,
  input  logic [1:0]  hilo_sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hilo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  op_e           op;
  logic          accept;
  logic          mt_en;
  logic [63:0]   prod;
  logic [31:0]   dvd, dvs, dvs_safe, quo, rem, quo_s, rem_s;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  assign op = op_e'(hilo_op[1:0]);

  // Codes 100-110 behave like 111, so only bit 2 clear marks a real operation.
  assign accept = start && !hilo_op[2] && !req && !busy_q;
  assign mt_en  = !whilo[1] && !req && !busy_q && !accept;

  // Operand arithmetic: signed divide via magnitudes, then sign fix-up.
  always_comb begin
    if (op == OP_MULT) prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else               prod = {32'b0, a} * {32'b0, b};
    dvd      = (op == OP_DIV && a[31]) ? -a : a;
    dvs      = (op == OP_DIV && b[31]) ? -b : b;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    quo      = dvd / dvs_safe;
    rem      = dvd % dvs_safe;
    quo_s    = (op == OP_DIV && (a[31] ^ b[31])) ? -quo : quo;
    rem_s    = (op == OP_DIV && a[31]) ? -rem : rem;
  end

  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (accept) begin
      if (hilo_op[1]) begin
        cnt_d     = CW'(DIV_CYCLES);
        pend_hi_d = rem_s;
        pend_lo_d = quo_s;
        pend_wr_d = (b != 32'd0);
      end else begin
        cnt_d     = CW'(MULT_CYCLES);
        pend_hi_d = prod[63:32];
        pend_lo_d = prod[31:0];
        pend_wr_d = 1'b1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end

    // Commit on the edge that drains the counter; divide-by-zero leaves HI/LO alone.
    if (cnt_q == CW'(1) && pend_wr_q) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (mt_en) begin
      if (whilo[0]) lo_d = a;
      else          hi_d = a;
    end

    busy_d = (cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    case (hilo_sel)
      2'b00:   hilo_out = hi_q;
      2'b01:   hilo_out = lo_q;
      default: hilo_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: fixed vectors with hand-computed HI/LO results,
// busy-length checks, req suppression and asynchronous reset abort.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  hilo_op;
  logic [1:0]  whilo;
  logic [1:0]  hilo_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hilo_out;

  int n_assert = 0;
  int n_fail   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .hilo_op  (hilo_op),
    .whilo    (whilo),
    .hilo_sel (hilo_sel),
    .a        (a),
    .b        (b),
    .req      (req),
    .busy     (busy),
    .hilo_out (hilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reads HI then LO through the mux, leaving hilo_sel on HI.
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    hilo_sel = 2'b00; #1 hi = hilo_out;
    hilo_sel = 2'b01; #1 lo = hilo_out;
    hilo_sel = 2'b00;
  endtask

  // A legal start must never arrive while an operation is in flight.
  always @(posedge clk) begin
    if (reset && start && !hilo_op[2] && !req) begin
      n_assert++;
      assert (busy === 1'b0) else begin
        n_fail++;
        $error("FAIL protocol: start while busy, observed busy %b expected 0", busy);
      end
    end
  end

  // Issue one operation at a negedge; count busy cycles; optionally pulse req.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int n_exp, input int req_at,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    logic [31:0] hi, lo, last_hi, last_lo;
    n = 0;
    last_hi = 'x;
    last_lo = 'x;
    start = 1'b1; hilo_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; hilo_op = 3'b111; a = 32'hDEADBEEF; b = 32'd0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      n++;
      read_hilo(last_hi, last_lo);
      req = (n == req_at);
      @(negedge clk);
    end
    req = 1'b0;
    check({tag, " busy cycles"}, 32'(n), 32'(n_exp));
    check({tag, " HI held while busy"}, last_hi, old_hi);
    check({tag, " LO held while busy"}, last_lo, old_lo);
    read_hilo(hi, lo);
    check({tag, " HI"}, hi, exp_hi);
    check({tag, " LO"}, lo, exp_lo);
  endtask

  initial begin
    logic [31:0] hi, lo;
    int n;

    reset = 1'b0; start = 1'b0; hilo_op = 3'b111; whilo = 2'b11;
    hilo_sel = 2'b11; a = '0; b = '0; req = 1'b0;
    #2;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset sel none", hilo_out, 32'd0);
    read_hilo(hi, lo);
    check("reset HI", hi, 32'd0);
    check("reset LO", lo, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // -3 * 5 = -15
    run_op("mult", 3'b000, 32'hFFFFFFFD, 32'd5, 5, 0,
           32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1);
    // 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'd2, 5, 0,
           32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000001, 32'hFFFFFFFE);
    hilo_sel = 2'b11; #1;
    check("sel none", hilo_out, 32'd0);
    hilo_sel = 2'b00;
    @(negedge clk);
    // -7 / 2 = -3 rem -1
    run_op("div", 3'b010, 32'hFFFFFFF9, 32'd2, 10, 0,
           32'h00000001, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu by zero", 3'b011, 32'd7, 32'd0, 10, 0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 10, 0,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);
    // 100 / 7 = 14 rem 2, and 100 code acts as no operation
    run_op("divu", 3'b011, 32'd100, 32'd7, 10, 0,
           32'h00000000, 32'h80000000, 32'd2, 32'd14);
    start = 1'b1; hilo_op = 3'b100; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; hilo_op = 3'b111;
    check("op 100 no busy", {31'd0, busy}, 32'd0);

    // mthi / mtlo with and without req
    whilo = 2'b00; a = 32'h12345678;
    @(negedge clk);
    whilo = 2'b11;
    read_hilo(hi, lo);
    check("mthi HI", hi, 32'h12345678);
    check("mthi LO untouched", lo, 32'd14);
    whilo = 2'b01; a = 32'hCAFEBABE; req = 1'b1;
    @(negedge clk);
    whilo = 2'b11; req = 1'b0;
    read_hilo(hi, lo);
    check("mtlo req LO", lo, 32'd14);
    whilo = 2'b01; a = 32'hCAFEBABE;
    @(negedge clk);
    whilo = 2'b11;
    read_hilo(hi, lo);
    check("mtlo LO", lo, 32'hCAFEBABE);
    start = 1'b1; hilo_op = 3'b000; a = 32'd2; b = 32'd3; req = 1'b1;
    @(negedge clk);
    start = 1'b0; hilo_op = 3'b111; req = 1'b0;
    check("mult req busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("mult req busy later", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("mult req HI", hi, 32'h12345678);
    check("mult req LO", lo, 32'hCAFEBABE);

    // Asynchronous reset in busy cycle 4 of a divide
    start = 1'b1; hilo_op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; hilo_op = 3'b111;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (busy) n++;
      if (n == 4) break;
      @(negedge clk);
    end
    check("abort reached busy 4", 32'(n), 32'd4);
    #2 reset = 1'b0;
    #1;
    check("abort busy", {31'd0, busy}, 32'd0);
    read_hilo(hi, lo);
    check("abort HI", hi, 32'd0);
    check("abort LO", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("no late busy", 32'(n), 32'd0);
    read_hilo(hi, lo);
    check("no late HI", hi, 32'd0);
    check("no late LO", lo, 32'd0);
    run_op("mult after reset", 3'b000, 32'd6, 32'd7, 5, 0,
           32'h0, 32'h0, 32'h0, 32'd42);

    // req in busy cycle 2 does not abort: -1 * -1 = 1
    run_op("mult with req", 3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 2,
           32'h0, 32'd42, 32'h0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multiply/divide unit in the E stage of the P7 pipelined MIPS core.
- Consumes the E-stage decode outputs `start`, `HILOOP`, `WHILO` and `HILOSel_E`, plus forwarded rs/rt operands.
- Runs multi-cycle mult/multu/div/divu, owns the HI/LO architectural registers, and exposes `busy` so the hazard unit can stall MDU instructions in D.
- Writes from E are suppressed when an exception/interrupt request flushes the instruction in E.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (legal range ≥1).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (legal range ≥1).

Ports:
- clk  input  1  pipeline clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  mult/multu/div/divu is in E this cycle.
- hilo_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 111 none.
- whilo  input  2  00 mthi, 01 mtlo, 11 none.
- hilo_sel  input  2  00 read HI (mfhi), 01 read LO (mflo), 11 none.
- a  input  32  forwarded rs value.
- b  input  32  forwarded rt value.
- req  input  1  exception/interrupt taken this cycle; E instruction is flushed.
- busy  output  1  operation in flight.
- hilo_out  output  32  HI/LO read data to the E/M pipeline register.

Behaviour:
- Reset (reset=0, async):
  - HI=0, LO=0, counter=0, pending HI/LO=0, busy=0.
  - Reset mid-operation aborts the operation; no HI/LO write ever occurs for it.
- States: IDLE (counter=0) and RUN (counter>0). `busy` = (counter != 0), registered.
- Accepted start: start=1, hilo_op ≠ 111, req=0, busy=0, sampled at edge k.
  - a and b are latched at edge k; the result is computed from the latched values into pending regs.
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - busy=1 from after edge k through edge k+N−1.
  - At edge k+N the counter reaches 0, HI/LO take the pending values, and busy falls on the same edge.
  - New HI/LO are visible to `hilo_out` from cycle k+N onward.
- start while busy=1: ignored; the hazard unit guarantees this does not occur. The bench flags it as a protocol error.
- start with req=1: ignored. A req arriving while in RUN does not abort; the in-flight operation completes and commits.
- mult: signed 64-bit product; HI=[63:32], LO=[31:0].
- multu: unsigned 64-bit product; HI=[63:32], LO=[31:0].
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / −1 gives LO=0x80000000, HI=0.
- divu: unsigned quotient in LO, unsigned remainder in HI.
- Divide by zero (div or divu, b=0): HI/LO unchanged at commit. busy still runs the full DIV_CYCLES.
- mthi/mtlo:
  - whilo=00 writes HI←a at the next edge; whilo=01 writes LO←a.
  - Suppressed if req=1 or busy=1.
  - If whilo and an accepted start arrive together, start wins and whilo is ignored (decode never produces both).
- Read path, combinational:
  - hilo_out = HI when hilo_sel=00, LO when hilo_sel=01, else 0.
  - Reads during busy return old HI/LO; the stall logic prevents mfhi/mflo reaching E while busy.
- hilo_op values 100–110: treated as 111 (no operation).

Test Plan:
- Reset, then start+mult with a=0xFFFFFFFD (−3), b=5 → busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy falls and HI/LO update on the same edge.
- multu a=0xFFFFFFFF, b=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles; hilo_sel=00 then 01 returns each value combinationally.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu a=7, b=0 → 10 busy cycles, HI/LO unchanged.
- mthi a=0x12345678 with req=0 → HI=0x12345678 next edge. mtlo a=0xCAFEBABE with req=1 → LO unchanged. start+mult with req=1 → busy stays 0.
- Start div, assert reset=0 asynchronously at busy cycle 4 → busy, HI, LO immediately 0. After release, no late commit occurs and a fresh mult completes normally.
- Start mult, pulse req=1 in busy cycle 2 → operation still commits at cycle 5 with the correct product.
